cpu4_bus_sequencer: RTL and testbench
=====================================

// Module: cpu4_bus_sequencer
// PURPOSE
//  Sequences the 4-bit accumulator CPU tile (8-bit io_in/io_out bus) from a system clock.
//  - Owns the CPU's 64x4 program/data memory.
//  - Generates the CPU clock and reset.
//  - Serves fetches and operand reads, and captures stores.
//  - Arbitrates the memory between the CPU and a host load/debug port.
//  - Provides run/halt/single-step and one address breakpoint.
// PARAMETERS
//  HALF_PERIOD  2   system clocks per cpu_clk phase; legal range 2..15.
//  CYC_W        16  width of the CPU cycle counter.
// PORTS
//  clk          in   1      system clock; all logic on rising edge.
//  rst_n        in   1      asynchronous, active-low reset.
//  cpu_io_in    out  8      to CPU io_in:
//                             [0] cpu_clk, [1] cpu reset (active-high), [5:2] data, [7:6] = 0.
//  cpu_io_out   in   8      from CPU io_out:
//                             [5:0] address or store data, [6] wcyc.
//  run          in   1      level; 1 = CPU free-runs.
//  step         in   1      1-clk pulse; one CPU cycle while halted.
//  cpu_rst      in   1      1-clk pulse; return to IDLE (CPU held in reset).
//  bp_en        in   1      breakpoint enable.
//  bp_addr      in   6      breakpoint fetch/read address.
//  host_valid   in   1      host request.
//  host_ready   out  1      host request accepted when valid & ready.
//  host_we      in   1      1 = write, 0 = read.
//  host_addr    in   6      host memory address.
//  host_wdata   in   4      host write data.
//  host_rdata   out  4      read data; valid when host_rvalid = 1.
//  host_rvalid  out  1      1-clk pulse, one cycle after an accepted read.
//  state_o      out  2      0 IDLE, 1 RUN_LO, 2 RUN_HI, 3 HALT.
//  cyc_count    out  CYC_W  cpu_clk rising edges since IDLE exit; saturates at all-ones.
// BEHAVIOUR
//  Reset (rst_n = 0):
//   - state IDLE, cpu_io_in = 8'b0000_0010, host_rdata = 0, host_rvalid = 0, cyc_count = 0.
//   - Phase counter and history nibbles (hist1, hist0) cleared; bp-skip flag cleared.
//   - Memory is NOT cleared. Async reset mid-cycle aborts any CPU cycle immediately.
//  Outputs by state:
//   - cpu_io_in[1] = 1 only in IDLE.
//   - cpu_io_in[0] = 1 only in RUN_HI.
//   - host_ready = 1 in IDLE and HALT, 0 in RUN_LO/RUN_HI.
//  State machine:
//   - IDLE:   run=1 -> RUN_LO; phase=0, hist cleared, cyc_count=0.
//   - RUN_LO: lasts HALF_PERIOD clks.
//       * At end of phase 0, sample cpu_io_out.
//       * wcyc=1: mem[{hist1[1:0],hist0}] <= cpu_io_out[3:0]; data nibble unchanged, hist unchanged.
//       * wcyc=0: data nibble <= mem[cpu_io_out[5:0]]; hist1 <= hist0, hist0 <= that nibble.
//       * Breakpoint: bp_en & wcyc=0 & address==bp_addr & !skip -> HALT after the sample.
//         Data is latched, cpu_clk stays 0, and cyc_count does not increment.
//       * Otherwise, at end of last phase: cpu_clk <= 1, cyc_count++, -> RUN_HI.
//   - RUN_HI: lasts HALF_PERIOD clks, then:
//       * cpu_rst pending -> IDLE.
//       * run=1 and not a step cycle -> RUN_LO.
//       * else -> HALT.
//   - HALT: cpu_clk = 0, CPU state preserved.
//       * cpu_rst -> IDLE.
//       * else run=1 -> RUN_LO.
//       * else step -> RUN_LO as a one-cycle step (returns to HALT after RUN_HI).
//       * Priority: cpu_rst > run > step.
//       * On every HALT exit, skip=1: the next sample ignores the breakpoint; skip clears after it.
//  Control-input rules:
//   - run falling during RUN_LO/RUN_HI: the current CPU cycle completes, then HALT.
//   - cpu_rst during RUN_LO/RUN_HI is registered and taken at end of RUN_HI.
//   - step outside HALT is ignored.
//  Host port:
//   - Accept on valid & ready. Write lands next clk.
//   - Read returns mem[host_addr] next clk with host_rvalid = 1 for one clk.
//   - An accept in the same cycle the state leaves IDLE/HALT completes normally; CPU and host never access memory in the same clk.
//  Store address: hist1/hist0 are the two nibbles served during the CPU's two address-operand cycles preceding its store cycle.
// TESTING
//  1. Reset: rst_n=0 -> cpu_io_in=8'h02, host_ready=1, state_o=0. Host write mem[5]=4'hA, then read 5 -> host_rdata=4'hA with one rvalid pulse.
//  2. Fetch: run=1, CPU model drives addr 6'h05 in RUN_LO -> cpu_io_in[5:2]=4'hA at least 1 clk before cpu_clk rises; cyc_count=1 after first rise.
//  3. Store: serve nibbles 4'h2 then 4'h7, then wcyc=1 with data 4'h9 -> mem[6'h27]=4'h9 (host readback after halt).
//  4. Breakpoint: bp_en=1, bp_addr=6'h03; CPU reaches addr 3 -> HALT, cpu_clk=0, cyc_count frozen. run=1 -> resumes without re-halting at 3.
//  5. Step: in HALT, single step pulse -> exactly one cpu_clk rise, cyc_count +1, back to HALT; host_ready=0 throughout the step.
//  6. Mid-op reset: pulse rst_n low during RUN_HI -> immediately IDLE, cpu_io_in=8'h02, memory contents retained.

Source files
------------

// File: rtl/cpu4_bus_sequencer.sv
// cpu4_bus_sequencer: drives the 4-bit CPU tile clock/reset, owns its 64x4 memory,
// and shares that memory with a host port under run/halt/step/breakpoint control.
module cpu4_bus_sequencer #(
  parameter int HALF_PERIOD = 2,
  parameter int CYC_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [7:0]       cpu_io_in,
  input  logic [7:0]       cpu_io_out,
  input  logic             run,
  input  logic             step,
  input  logic             cpu_rst,
  input  logic             bp_en,
  input  logic [5:0]       bp_addr,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             host_we,
  input  logic [5:0]       host_addr,
  input  logic [3:0]       host_wdata,
  output logic [3:0]       host_rdata,
  output logic             host_rvalid,
  output logic [1:0]       state_o,
  output logic [CYC_W-1:0] cyc_count
);
  typedef enum logic [1:0] {IDLE, RUN_LO, RUN_HI, HALT} state_t;
  localparam logic [3:0] LAST = 4'(HALF_PERIOD - 1);
  logic [3:0] mem [64];
  state_t state_q, state_d;
  logic [3:0] phase_q, phase_d, data_q, data_d, hist1_q, hist1_d, hist0_q, hist0_d, rdata_q, rdata_d;
  logic skip_q, skip_d, pend_q, pend_d, stepc_q, stepc_d, rvalid_q, rvalid_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic mem_we;
  logic [5:0] mem_wa;
  logic [3:0] mem_wd, cpu_nib;
  logic accept, wcyc, bp_hit, rst_req, unused_io;
  assign wcyc       = cpu_io_out[6];
  assign cpu_nib    = mem[cpu_io_out[5:0]];
  assign host_ready = state_q == IDLE || state_q == HALT;
  assign accept     = host_valid && host_ready;
  assign rst_req    = pend_q || cpu_rst;
  assign bp_hit     = bp_en && !wcyc && cpu_io_out[5:0] == bp_addr && !skip_q;
  assign unused_io  = cpu_io_out[7];
  // Host accesses only happen in IDLE/HALT and CPU accesses only in RUN_LO, so one write port suffices.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    data_d   = data_q;
    hist1_d  = hist1_q;
    hist0_d  = hist0_q;
    skip_d   = skip_q;
    pend_d   = pend_q;
    stepc_d  = stepc_q;
    cyc_d    = cyc_q;
    rdata_d  = accept && !host_we ? mem[host_addr] : rdata_q;
    rvalid_d = accept && !host_we;
    mem_we   = accept && host_we;
    mem_wa   = host_addr;
    mem_wd   = host_wdata;
    case (state_q)
      IDLE: if (run) begin
        state_d = RUN_LO;
        phase_d = '0;
        hist1_d = '0;
        hist0_d = '0;
        cyc_d   = '0;
        pend_d  = 1'b0;
        stepc_d = 1'b0;
      end
      RUN_LO: begin
        pend_d  = rst_req;
        phase_d = phase_q + 4'd1;
        if (phase_q == '0) begin
          skip_d = 1'b0;
          if (wcyc) begin
            mem_we = 1'b1;
            mem_wa = {hist1_q[1:0], hist0_q};
            mem_wd = cpu_io_out[3:0];
          end else begin
            data_d  = cpu_nib;
            hist1_d = hist0_q;
            hist0_d = cpu_nib;
          end
          if (bp_hit) begin
            state_d = HALT;
            phase_d = '0;
          end
        end else if (phase_q == LAST) begin
          state_d = RUN_HI;
          phase_d = '0;
          cyc_d   = &cyc_q ? cyc_q : cyc_q + 1'b1;
        end
      end
      RUN_HI: begin
        pend_d  = rst_req;
        phase_d = phase_q + 4'd1;
        if (phase_q == LAST) begin
          phase_d = '0;
          pend_d  = 1'b0;
          state_d = rst_req ? IDLE : run && !stepc_q ? RUN_LO : HALT;
        end
      end
      HALT: if (rst_req || run || step) begin
        skip_d  = 1'b1;
        pend_d  = 1'b0;
        stepc_d = !run;
        phase_d = '0;
        state_d = rst_req ? IDLE : RUN_LO;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      data_q   <= '0;
      hist1_q  <= '0;
      hist0_q  <= '0;
      rdata_q  <= '0;
      skip_q   <= 1'b0;
      pend_q   <= 1'b0;
      stepc_q  <= 1'b0;
      rvalid_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      hist1_q  <= hist1_d;
      hist0_q  <= hist0_d;
      rdata_q  <= rdata_d;
      skip_q   <= skip_d;
      pend_q   <= pend_d;
      stepc_q  <= stepc_d;
      rvalid_q <= rvalid_d;
      cyc_q    <= cyc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end
  assign cpu_io_in   = {2'b00, data_q, state_q == IDLE, state_q == RUN_HI};
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign state_o     = state_q;
  assign cyc_count   = cyc_q;
endmodule

// File: tb/tb_cpu4_bus_sequencer.sv
// tb_cpu4_bus_sequencer: directed scenarios plus random stimulus, all checked every cycle
// against a timeline-based model of the sequencer and its memory.
module tb_cpu4_bus_sequencer;
  localparam int HP = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] cpu_io_in, cpu_io_out = 8'h00;
  logic run = 0, step = 0, cpu_rst = 0, bp_en = 0, host_valid = 0, host_we = 0;
  logic [5:0] bp_addr = 0, host_addr = 0;
  logic [3:0] host_wdata = 0, host_rdata;
  logic host_ready, host_rvalid;
  logic [1:0] state_o;
  logic [15:0] cyc_count;

  cpu4_bus_sequencer #(.HALF_PERIOD(HP), .CYC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_io_in(cpu_io_in), .cpu_io_out(cpu_io_out),
    .run(run), .step(step), .cpu_rst(cpu_rst), .bp_en(bp_en), .bp_addr(bp_addr),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .state_o(state_o), .cyc_count(cyc_count));

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 running, 3 halted; t = clocks elapsed in the current CPU cycle.
  int m_mode, m_t, m_cyc;
  bit m_stepping, m_rreq, m_skip, m_rvalid, m_hit;
  logic [3:0] m_data, m_h1, m_h0, m_rdata;
  logic [3:0] m_mem [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_cyc = 0; m_stepping = 0; m_rreq = 0; m_skip = 0;
      m_rvalid = 0; m_data = 0; m_h1 = 0; m_h0 = 0; m_rdata = 0;
    end else begin
      m_rvalid = 0;
      if (host_valid && m_mode != 1) begin
        if (host_we) m_mem[host_addr] = host_wdata;
        else begin m_rdata = m_mem[host_addr]; m_rvalid = 1; end
      end
      if (m_mode == 0) begin
        if (run) begin m_mode = 1; m_t = 0; m_h1 = 0; m_h0 = 0; m_cyc = 0; m_stepping = 0; m_rreq = 0; end
      end else if (m_mode == 3) begin
        if (cpu_rst || m_rreq) begin m_mode = 0; m_rreq = 0; m_skip = 1; end
        else if (run || step) begin m_mode = 1; m_t = 0; m_skip = 1; m_stepping = !run; end
      end else begin
        m_rreq = m_rreq | cpu_rst;
        m_hit = 0;
        if (m_t == 0) begin
          if (cpu_io_out[6]) m_mem[{m_h1[1:0], m_h0}] = cpu_io_out[3:0];
          else begin
            m_data = m_mem[cpu_io_out[5:0]]; m_h1 = m_h0; m_h0 = m_data;
            m_hit = bp_en && cpu_io_out[5:0] == bp_addr && !m_skip;
          end
          m_skip = 0;
        end
        if (m_hit) begin m_mode = 3; m_t = 0; end
        else begin
          m_t++;
          if (m_t == HP && m_cyc != 16'hFFFF) m_cyc++;
          if (m_t == 2 * HP) begin
            m_t = 0;
            if (m_rreq) begin m_mode = 0; m_rreq = 0; end
            else if (!(run && !m_stepping)) m_mode = 3;
          end
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0, rises, ready_lo;
  bit mdl_on = 0;
  logic prev_clk;
  logic [1:0] m_state;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mdl_on) begin
      m_state = m_mode == 1 ? (m_t < HP ? 2'd1 : 2'd2) : 2'(m_mode);
      chk("state_o", state_o, m_state);
      chk("cpu_io_in", cpu_io_in, {2'b00, m_data, m_state == 0, m_state == 2});
      chk("host_ready", host_ready, m_mode != 1);
      chk("host_rvalid", host_rvalid, m_rvalid);
      chk("host_rdata", host_rdata, m_rdata);
      chk("cyc_count", cyc_count, m_cyc[15:0]);
    end
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s);
    int k = 0;
    while (state_o !== s && k < 200) begin tick(); k++; end
    chk("wait_state", state_o, s);
  endtask

  task automatic host_wr(input logic [5:0] a, input logic [3:0] d);
    host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
    tick();
    host_valid = 0;
  endtask

  task automatic host_rd(input logic [5:0] a, input logic [3:0] exp);
    host_valid = 1; host_we = 0; host_addr = a;
    tick();
    host_valid = 0;
    chk("rd_rvalid", host_rvalid, 1'b1);
    chk("rd_data", host_rdata, exp);
    tick();
    chk("rd_rvalid_drop", host_rvalid, 1'b0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_io_in", cpu_io_in, 8'h02);
    chk("rst_ready", host_ready, 1'b1);
    chk("rst_state", state_o, 2'd0);
    chk("rst_cyc", cyc_count, 16'd0);
    mdl_on = 1;
    rst_n = 1;
    tick();
    for (int i = 0; i < 64; i++) host_wr(6'(i), 4'(i) ^ 4'hF);
    host_wr(6'h05, 4'hA);
    host_rd(6'h05, 4'hA);
    // fetch
    run = 1; cpu_io_out = 8'h05;
    tick(); chk("fetch_lo0", cpu_io_in, 8'h00);
    tick(); chk("fetch_data", cpu_io_in, 8'h28);
    tick(); chk("fetch_rise", cpu_io_in, 8'h29); chk("fetch_cyc", cyc_count, 16'd1);
    // store to {2,7}
    cpu_io_out = 8'h0D; wait_state(1); wait_state(2);
    cpu_io_out = 8'h08; wait_state(1); wait_state(2);
    cpu_io_out = 8'h49; wait_state(1); wait_state(2);
    run = 0; cpu_io_out = 8'h00; wait_state(3);
    chk("store_data_kept", cpu_io_in, 8'h1C);
    chk("store_cyc", cyc_count, 16'd4);
    host_rd(6'h27, 4'h9);
    // breakpoint at 3
    bp_en = 1; bp_addr = 6'h03; cpu_io_out = 8'h01; run = 1;
    wait_state(2);
    cpu_io_out = 8'h03;
    wait_state(3);
    run = 0;
    chk("bp_io_in", cpu_io_in, 8'h30);
    chk("bp_cyc", cyc_count, 16'd5);
    repeat (4) tick();
    chk("bp_hold_state", state_o, 2'd3);
    chk("bp_hold_cyc", cyc_count, 16'd5);
    run = 1; wait_state(2);
    chk("bp_resume_cyc", cyc_count, 16'd6);
    run = 0; wait_state(3);
    chk("bp_resume_halt_cyc", cyc_count, 16'd6);
    // single step
    cpu_io_out = 8'h02; step = 1; rises = 0; ready_lo = 0; prev_clk = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      step = 0;
      if (cpu_io_in[0] && !prev_clk) rises++;
      prev_clk = cpu_io_in[0];
      if (!host_ready) ready_lo++;
    end
    chk("step_rises", rises, 1);
    chk("step_ready_lo", ready_lo, 2 * HP);
    chk("step_state", state_o, 2'd3);
    chk("step_cyc", cyc_count, 16'd7);
    chk("step_data", cpu_io_in, 8'h34);
    // async reset in RUN_HI
    run = 1; wait_state(2);
    rst_n = 0; #1;
    chk("arst_state", state_o, 2'd0);
    chk("arst_io_in", cpu_io_in, 8'h02);
    run = 0; bp_en = 0;
    tick(); rst_n = 1; tick();
    host_rd(6'h27, 4'h9);
    host_rd(6'h05, 4'hA);
    // random phase
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 11) == 0) run = !run;
      step = $urandom_range(0, 7) == 0;
      cpu_rst = $urandom_range(0, 63) == 0;
      bp_en = $urandom_range(0, 1) == 0;
      bp_addr = 6'($urandom_range(0, 3));
      cpu_io_out = {1'($urandom), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'($urandom_range(0, 3))};
      host_valid = $urandom_range(0, 1) == 1;
      host_we = $urandom_range(0, 2) == 0;
      host_addr = 6'($urandom);
      host_wdata = 4'($urandom);
      rst_n = $urandom_range(0, 499) != 0;
    end
    rst_n = 1; run = 0; step = 0; cpu_rst = 0; host_valid = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
